// File: rtl/seq_logic_unit.sv
// Slice-serial bitwise logic unit (AND/OR/XOR/NOR) with valid/ready request and result handshakes.
// Optional macro SEQ_LOGIC_FASTPATH_EN computes the whole word in a single BUSY edge.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a request transfers on an edge with in_valid && in_ready; a result
  // transfers on an edge with out_valid && out_ready. Each valid/ready is ignored otherwise.
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, full;
  logic [1:0]       op_q;
  logic             en_q;
  logic             accept;
  logic             last_slice;

  assign accept     = in_valid && (state == IDLE);
  assign last_slice = (cnt == CW'(NSLICE - 1));

  always_comb begin
    full = '0;
    case (op_q)
      2'b00:   full = a_q & b_q;
      2'b01:   full = a_q | b_q;
      2'b10:   full = a_q ^ b_q;
      default: full = ~(a_q | b_q);
    endcase
    if (!en_q) full = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = BUSY;
`ifdef SEQ_LOGIC_FASTPATH_EN
      BUSY: state_n = DONE;
`else
      BUSY: if (last_slice) state_n = DONE;
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are frozen at accept so later input changes cannot disturb the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      out   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      en_q  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      out   <= '0;
      a_q   <= in1;
      b_q   <= in2;
      op_q  <= op;
      en_q  <= enable;
    end else if (state == BUSY) begin
`ifdef SEQ_LOGIC_FASTPATH_EN
      out <= full;
`else
      for (int k = 0; k < NSLICE; k++) begin
        if (cnt == CW'(k)) out[k*SLICE +: SLICE] <= full[k*SLICE +: SLICE];
      end
`endif
      // Saturate on the final slice so the counter never wraps within an operation.
      if (!last_slice) cnt <= cnt + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign zero      = ~|out;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Bench for seq_logic_unit: directed vectors, reset mid-operation, then randomized
// transactions checked against a truth-table reference model and an expected-result queue.
module tb_seq_logic_unit;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;
`ifdef SEQ_LOGIC_FASTPATH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = NSLICE;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in1 = '0, in2 = '0;
  logic [1:0]       op = '0;
  logic             enable = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_w;
  logic             zero;
  logic             busy;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  seq_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .enable(enable), .out_valid(out_valid),
    .out_ready(out_ready), .out(out_w), .zero(zero), .busy(busy), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: per-bit truth table indexed by {a,b}, one 4-bit row per opcode.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [1:0] o, input logic en);
    logic [3:0] tt [4];
    logic [3:0] row;
    logic [WIDTH-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
    row = tt[o];
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = en ? row[{a[i], b[i]}] : 1'b0;
    return r;
  endfunction

  // Bits filled after k BUSY edges in slice-serial mode.
  function automatic logic [WIDTH-1:0] filled_mask(input int k);
    logic [WIDTH:0] m;
    if (LAT == 1 || k >= NSLICE) return '1;
    m = ({{WIDTH{1'b0}}, 1'b1} << (k * SLICE)) - 1;
    return m[WIDTH-1:0];
  endfunction

  task automatic scramble_inputs();
    in1 = $urandom; in2 = $urandom; op = 2'($urandom_range(0, 3)); enable = 1'($urandom_range(0, 1));
  endtask

  // driver: issue one request from IDLE (called at a negedge), walk it through BUSY,
  // hold it in DONE for 'hold' cycles with in_valid asserted, then release it.
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] o, input logic en, input int hold,
                         input logic valid_at_release);
    logic [WIDTH-1:0] full, exp;
    int edges;
    full = ref_model(a, b, o, en);
    exp_q.push_back(full);
    check("idle_in_ready", in_ready, 1);
    in1 = a; in2 = b; op = o; enable = en; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    check("accept_busy", busy, 1);
    check("accept_out_cleared", out_w, 0);
    check("accept_in_ready", in_ready, 0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
      scramble_inputs();
      if (!out_valid) check("partial_out", out_w, full & filled_mask(edges));
    end
    check("latency", edges, LAT);
    exp = exp_q.pop_front();
    check("result", out_w, exp);
    check("zero", zero, (exp == '0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_stable", out_w, exp);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 0);
    end
    in_valid = valid_at_release;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_no_accept", busy, 0);
    check("idle_retains_out", out_w, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] last;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out_w, 0);
    check("rst_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 1'b1, 0, 1'b0);
    check("vec_and", out_w, 32'h0F0F0000);
    run_txn(32'hFFFFFFFF, 32'h00000000, 2'b11, 1'b1, 1, 1'b0);
    check("vec_nor", out_w, 32'h00000000);
    run_txn(32'hFFFFFFFF, 32'h00000000, 2'b01, 1'b1, 0, 1'b0);
    check("vec_or", out_w, 32'hFFFFFFFF);
    run_txn(32'hAAAAAAAA, 32'h55555555, 2'b10, 1'b0, 0, 1'b0);
    check("vec_disabled", out_w, 32'h00000000);
    run_txn(32'hAAAAAAAA, 32'h55555555, 2'b10, 1'b1, 10, 1'b1);
    check("vec_xor", out_w, 32'hFFFFFFFF);

    // out_ready while idle has no effect
    last = out_w;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_in_ready", in_ready, 1);
    check("idle_ready_out_valid", out_valid, 0);
    check("idle_ready_out", out_w, last);

    // reset after two BUSY edges discards the operation
    in1 = 32'h12345678; in2 = 32'hFFFFFFFF; op = 2'b00; enable = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (LAT > 2) check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", out_w, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_zero", zero, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", in_ready, 1);
    check("post_rst_out", out_w, 0);
    run_txn(32'hDEADBEEF, 32'h0000FFFF, 2'b10, 1'b1, 2, 1'b0);

    for (int t = 0; t < 25; t++) begin
      run_txn($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits.
REQ-002 Parameter SLICE, 8, bits processed per BUSY cycle; SLICE SHALL divide WIDTH exactly (NSLICE = WIDTH/SLICE).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 In_valid  input  1  request present.
REQ-006 In_ready  output  1  block can accept a request.
REQ-007 In1  input  WIDTH  operand A.
REQ-008 In2  input  WIDTH  operand B.
REQ-009 Op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 Enable  input  1  high = compute; low = result forced to zero.
REQ-011 Out_valid  output  1  result available.
REQ-012 Out_ready  input  1  consumer takes result.
REQ-013 Out  output  WIDTH  result register.
REQ-014 Zero  output  1  high when Out is all zeros (~|Out).
REQ-015 Busy  output  1  high while in BUSY state.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, DONE; In_ready = (state==IDLE), Busy = (state==BUSY), Out_valid = (state==DONE).
REQ-017 Accept occurs on a rising edge with In_valid && In_ready: capture In1, In2, Op, Enable; clear Out to 0; clear slice counter to 0; go to BUSY.
REQ-018 In BUSY, each edge SHALL write Out[k*SLICE +: SLICE] = Op(In1,In2) over captured slice k (or 0 if captured Enable=0), then increment k.
REQ-019 After the edge writing slice NSLICE-1, the FSM SHALL enter DONE; Out_valid rises NSLICE edges after the accept edge (4 for defaults).
REQ-020 Inputs In1/In2/Op/Enable changing after accept SHALL NOT affect the operation in progress.
REQ-021 In DONE, Out and Zero SHALL remain stable until an edge with Out_ready=1, which returns the FSM to IDLE.
REQ-022 In_valid in BUSY or DONE SHALL be ignored (no accept); In_valid and Out_ready high in the same DONE cycle: return to IDLE, new request accepted no earlier than the next edge.
REQ-023 Out_ready while Out_valid=0 SHALL be ignored.
REQ-024 Out SHALL retain the last result in IDLE until the next accept.
REQ-025 The slice counter SHALL be ceil(log2(NSLICE)) bits, min 1, and never wrap within an operation.

Reset
REQ-026 Rst_n low SHALL immediately (asynchronously) force state=IDLE, counter=0, Out=0; hence In_ready=1, Out_valid=0, Busy=0, Zero=1.
REQ-027 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no partial result visible after release.
REQ-028 Operation SHALL resume with the first rising edge after Rst_n returns high.

Configuration
REQ-029 Macro SEQ_LOGIC_FASTPATH_EN: when defined, BUSY SHALL last exactly one edge, computing all WIDTH bits at once (Out_valid one edge after accept); when undefined, slice-serial behaviour of REQ-018/019 applies. Ports and handshake identical in both builds.

Verification (WIDTH=32, SLICE=8)
REQ-030 In1=0xFFFF0000, In2=0x0F0F0F0F, Op=00, Enable=1 -> Out_valid 4 edges after accept, Out=0x0F0F0000, Zero=0.
REQ-031 In1=0xFFFFFFFF, In2=0x00000000, Op=11 -> Out=0x00000000, Zero=1; Op=01 same operands -> Out=0xFFFFFFFF.
REQ-032 In1=0xAAAAAAAA, In2=0x55555555, Op=10, Enable=0 -> Out=0x00000000, Zero=1, latency still 4.
REQ-033 Out_ready held low 10 cycles in DONE with In_valid=1 -> Out_valid stays 1, Out stable, In_ready=0, no second accept; Out_ready=1 -> IDLE next edge.
REQ-034 Rst_n pulsed low after 2 BUSY edges -> same instant Out=0, Busy=0, In_ready=1, Out_valid=0; following request completes normally.
REQ-035 With SEQ_LOGIC_FASTPATH_EN defined, REQ-030 stimulus -> Out_valid 1 edge after accept, Out=0x0F0F0000.
